// File: rtl/fadsu8_mp_seq_pkg.sv
// Shared definitions for the multi-precision add/sub sequencer.
// Contents: byte width, CON encodings, FSM state type, overflow helper.
package fadsu8_mp_seq_pkg;

  localparam int unsigned BYTE_W = 8;

  localparam logic CON_ADD = 1'b1;
  localparam logic CON_SUB = 1'b0;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  // Two's-complement overflow from the operand and result sign bits.
  // Subtract overflows when the operands differ in sign and the result
  // sign differs from the minuend.
  function automatic logic calc_ovf(logic con, logic a7, logic b7, logic s7);
    if (con == CON_SUB) begin
      return (a7 != b7) && (s7 != a7);
    end
    return (a7 == b7) && (s7 != a7);
  endfunction

endpackage

// File: rtl/fadsu8_mp_seq_if.sv
// Bus interface of the multi-precision add/sub sequencer.
// Request side : START, CON, A, B in; BUSY, DONE, RES, CO, OVF out.
// Macro side   : FA_A, FA_B, FA_BCI, FA_CON out; FA_S, FA_BCO in.
// slave  = view of the sequencer itself, master = view of its environment.
interface fadsu8_mp_seq_if
  import fadsu8_mp_seq_pkg::*;
#(
  parameter int unsigned NBYTES = 4
) ();

  logic                     START;
  logic                     CON;
  logic [BYTE_W*NBYTES-1:0] A;
  logic [BYTE_W*NBYTES-1:0] B;
  logic                     BUSY;
  logic                     DONE;
  logic [BYTE_W*NBYTES-1:0] RES;
  logic                     CO;
  logic                     OVF;
  logic [BYTE_W-1:0]        FA_A;
  logic [BYTE_W-1:0]        FA_B;
  logic                     FA_BCI;
  logic                     FA_CON;
  logic [BYTE_W-1:0]        FA_S;
  logic                     FA_BCO;

  modport slave (
    input  START, CON, A, B, FA_S, FA_BCO,
    output BUSY, DONE, RES, CO, OVF, FA_A, FA_B, FA_BCI, FA_CON
  );

  modport master (
    output START, CON, A, B, FA_S, FA_BCO,
    input  BUSY, DONE, RES, CO, OVF, FA_A, FA_B, FA_BCI, FA_CON
  );

endinterface

// File: rtl/fadsu8_mp_seq_mp_shift_reg.sv
// Byte-wide shift register, NBYTES lanes.
// Ports: clk_i, rst_i (sync, active-high), load_i/load_data_i parallel load,
// shift_i shifts right one byte with byte_i entering the top lane,
// data_o the full register contents.
module mp_shift_reg
  import fadsu8_mp_seq_pkg::*;
#(
  parameter int unsigned NBYTES = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     load_i,
  input  logic [BYTE_W*NBYTES-1:0] load_data_i,
  input  logic                     shift_i,
  input  logic [BYTE_W-1:0]        byte_i,
  output logic [BYTE_W*NBYTES-1:0] data_o
);

  localparam int unsigned W = BYTE_W * NBYTES;

  logic [W-1:0] data_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q <= '0;
    end else if (load_i) begin
      data_q <= load_data_i;
    end else if (shift_i) begin
      data_q <= {byte_i, data_q[W-1:BYTE_W]};
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/fadsu8_mp_seq.sv
// Multi-precision add/sub sequencer driving an external 8-bit add/sub macro.
// Ports: CK clock, RST sync active-high reset, bus (slave modport) carrying
// the request/result handshake and the byte-serial macro connection.
// Operands are fed LSB byte first, one byte per cycle; the macro's carry is
// registered between bytes and result bytes shift in from the top.
module fadsu8_mp_seq
  import fadsu8_mp_seq_pkg::*;
#(
  parameter int unsigned NBYTES = 4
) (
  input logic            CK,
  input logic            RST,
  fadsu8_mp_seq_if.slave bus
);

  localparam int unsigned W    = BYTE_W * NBYTES;
  localparam int unsigned IdxW = $clog2(NBYTES);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NBYTES - 1);

  state_e            state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic              carry_q, carry_d;
  logic              con_q, con_d;
  logic              co_q, co_d;
  logic              ovf_q, ovf_d;

  logic [W-1:0]      a_sr, b_sr, res_sr;
  logic [BYTE_W-1:0] a_byte, b_byte;
  logic              run, accept, last;

  assign run    = (state_q == StRun);
  // A request is taken in IDLE and in DONE (back-to-back), never in RUN.
  assign accept = bus.START && !run;
  assign last   = run && (idx_q == LastIdx);
  assign a_byte = a_sr[BYTE_W-1:0];
  assign b_byte = b_sr[BYTE_W-1:0];

  // Only the low lane of each operand is consumed; upper lanes just shift down.
  logic unused_hi;
  assign unused_hi = ^{a_sr[W-1:BYTE_W], b_sr[W-1:BYTE_W]};

  mp_shift_reg #(.NBYTES(NBYTES)) u_a_sr (
    .clk_i       (CK),
    .rst_i       (RST),
    .load_i      (accept),
    .load_data_i (bus.A),
    .shift_i     (run),
    .byte_i      ('0),
    .data_o      (a_sr)
  );

  mp_shift_reg #(.NBYTES(NBYTES)) u_b_sr (
    .clk_i       (CK),
    .rst_i       (RST),
    .load_i      (accept),
    .load_data_i (bus.B),
    .shift_i     (run),
    .byte_i      ('0),
    .data_o      (b_sr)
  );

  mp_shift_reg #(.NBYTES(NBYTES)) u_res_sr (
    .clk_i       (CK),
    .rst_i       (RST),
    .load_i      (1'b0),
    .load_data_i ('0),
    .shift_i     (run),
    .byte_i      (bus.FA_S),
    .data_o      (res_sr)
  );

  // FSM state register.
  always_ff @(posedge CK) begin
    if (RST) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.START) state_d = StRun;
      StRun:   if (last) state_d = StDone;
      StDone:  state_d = bus.START ? StRun : StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs: the macro only sees live operands while running.
  always_comb begin
    bus.BUSY   = run;
    bus.DONE   = (state_q == StDone);
    bus.FA_A   = '0;
    bus.FA_B   = '0;
    bus.FA_BCI = 1'b0;
    bus.FA_CON = 1'b0;
    if (run) begin
      bus.FA_A   = a_byte;
      bus.FA_B   = b_byte;
      bus.FA_BCI = carry_q;
      bus.FA_CON = con_q;
    end
  end

  // Datapath next state.
  always_comb begin
    idx_d   = idx_q;
    carry_d = carry_q;
    con_d   = con_q;
    co_d    = co_q;
    ovf_d   = ovf_q;
    if (accept) begin
      idx_d   = '0;
      // Subtract starts with "no borrow" asserted.
      carry_d = ~bus.CON;
      con_d   = bus.CON;
    end else if (run) begin
      idx_d   = idx_q + 1'b1;
      carry_d = bus.FA_BCO;
      if (last) begin
        // Latched on the top byte so CO/OVF persist past the DONE cycle.
        co_d  = bus.FA_BCO;
        ovf_d = calc_ovf(con_q, a_byte[BYTE_W-1], b_byte[BYTE_W-1], bus.FA_S[BYTE_W-1]);
      end
    end
  end

  always_ff @(posedge CK) begin
    if (RST) begin
      idx_q   <= '0;
      carry_q <= 1'b0;
      con_q   <= 1'b0;
      co_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      carry_q <= carry_d;
      con_q   <= con_d;
      co_q    <= co_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.RES = res_sr;
  assign bus.CO  = co_q;
  assign bus.OVF = ovf_q;

endmodule

// File: tb/tb_fadsu8_mp_seq.sv
// Self-checking bench for fadsu8_mp_seq with NBYTES = 4 and a behavioural
// 8-bit add/sub macro attached to the FA_* bus.
module tb_fadsu8_mp_seq;
  import fadsu8_mp_seq_pkg::*;

  localparam int unsigned NB = 4;

  logic CK;
  logic RST;

  fadsu8_mp_seq_if #(.NBYTES(NB)) bus ();

  fadsu8_mp_seq #(.NBYTES(NB)) dut (
    .CK  (CK),
    .RST (RST),
    .bus (bus)
  );

  // 8-bit macro: add with carry, or subtract as A + ~B + not-borrow.
  assign {bus.FA_BCO, bus.FA_S} = {1'b0, bus.FA_A}
                                + {1'b0, (bus.FA_CON ? bus.FA_B : ~bus.FA_B)}
                                + 9'(bus.FA_BCI);

  initial CK = 1'b0;
  always #5 CK = ~CK;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        con;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        co;
    logic        ovf;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Full-width reference: plain integer arithmetic on the whole operands.
  task automatic ref_model(input logic con, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] r, output logic co, output logic ovf);
    longint sa;
    longint sb;
    longint s;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (con == CON_ADD) begin
      {co, r} = {1'b0, a} + {1'b0, b};
      s = sa + sb;
    end else begin
      r  = a - b;
      co = (a >= b);
      s  = sa - sb;
    end
    ovf = (s != longint'($signed(r)));
  endtask

  // Present a request for one cycle, then scramble the inputs.
  task automatic start_op(input logic con, input logic [31:0] a, input logic [31:0] b);
    @(negedge CK);
    bus.START = 1'b1;
    bus.CON   = con;
    bus.A     = a;
    bus.B     = b;
    @(posedge CK);
    #1;
    bus.START = 1'b0;
    bus.CON   = ~con;
    bus.A     = $urandom;
    bus.B     = $urandom;
  endtask

  // Cycles from the current point until DONE, bounded.
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!bus.DONE && cyc < 20) begin
      @(posedge CK);
      #1;
      cyc++;
    end
  endtask

  task automatic count_dones(input int n, output int seen);
    seen = 0;
    for (int k = 0; k < n; k++) begin
      @(posedge CK);
      #1;
      if (bus.DONE) seen++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout got=running exp=finished");
    $fatal(1);
  end

  initial begin
    int          cyc;
    int          seen;
    logic [31:0] r;
    logic        co;
    logic        ovf;
    logic        con;
    logic [31:0] a;
    logic [31:0] b;

    vecs[0] = '{con: 1'b1, a: 32'h0000_00FF, b: 32'h0000_0001, res: 32'h0000_0100, co: 1'b0, ovf: 1'b0};
    vecs[1] = '{con: 1'b0, a: 32'h0000_0000, b: 32'h0000_0001, res: 32'hFFFF_FFFF, co: 1'b0, ovf: 1'b0};
    vecs[2] = '{con: 1'b1, a: 32'h7FFF_FFFF, b: 32'h0000_0001, res: 32'h8000_0000, co: 1'b0, ovf: 1'b1};
    vecs[3] = '{con: 1'b1, a: 32'hFFFF_FFFF, b: 32'h0000_0001, res: 32'h0000_0000, co: 1'b1, ovf: 1'b0};
    vecs[4] = '{con: 1'b0, a: 32'h1234_5678, b: 32'h1234_5678, res: 32'h0000_0000, co: 1'b1, ovf: 1'b0};
    vecs[5] = '{con: 1'b0, a: 32'h8000_0000, b: 32'h0000_0001, res: 32'h7FFF_FFFF, co: 1'b1, ovf: 1'b1};

    RST       = 1'b1;
    bus.START = 1'b0;
    bus.CON   = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    repeat (3) @(posedge CK);
    #1;
    chk("reset busy", 32'(bus.BUSY), 32'd0);
    chk("reset done", 32'(bus.DONE), 32'd0);
    chk("reset res", bus.RES, 32'd0);
    chk("reset co_ovf", {30'd0, bus.CO, bus.OVF}, 32'd0);
    chk("reset fa", {14'd0, bus.FA_A, bus.FA_B, bus.FA_BCI, bus.FA_CON}, 32'd0);
    @(negedge CK);
    RST = 1'b0;

    // Directed vectors, each started from IDLE.
    for (int i = 0; i < 6; i++) begin
      repeat (2) @(posedge CK);
      #1;
      chk($sformatf("vec%0d idle done", i), 32'(bus.DONE), 32'd0);
      start_op(vecs[i].con, vecs[i].a, vecs[i].b);
      chk($sformatf("vec%0d busy", i), 32'(bus.BUSY), 32'd1);
      wait_done(cyc);
      chk($sformatf("vec%0d latency", i), 32'(cyc), 32'd4);
      chk($sformatf("vec%0d res", i), bus.RES, vecs[i].res);
      chk($sformatf("vec%0d co", i), 32'(bus.CO), 32'(vecs[i].co));
      chk($sformatf("vec%0d ovf", i), 32'(bus.OVF), 32'(vecs[i].ovf));
      chk($sformatf("vec%0d fa in done", i),
          {14'd0, bus.FA_A, bus.FA_B, bus.FA_BCI, bus.FA_CON}, 32'd0);
    end

    // Results and flags persist after DONE.
    repeat (3) @(posedge CK);
    #1;
    chk("hold done", 32'(bus.DONE), 32'd0);
    chk("hold res", bus.RES, 32'h7FFF_FFFF);
    chk("hold co_ovf", {30'd0, bus.CO, bus.OVF}, 32'd3);

    // Back-to-back: request held in the DONE cycle.
    start_op(1'b1, 32'h10, 32'h20);
    wait_done(cyc);
    chk("b2b first res", bus.RES, 32'h30);
    start_op(1'b1, 32'h1, 32'h2);
    wait_done(cyc);
    chk("b2b latency", 32'(cyc), 32'd4);
    chk("b2b res", bus.RES, 32'h3);

    // START during RUN is ignored and not queued.
    repeat (2) @(posedge CK);
    start_op(1'b1, 32'h5, 32'h3);
    @(negedge CK);
    bus.START = 1'b1;
    bus.CON   = 1'b0;
    bus.A     = 32'hDEAD_BEEF;
    bus.B     = 32'h0000_1111;
    @(posedge CK);
    #1;
    bus.START = 1'b0;
    wait_done(cyc);
    chk("run start latency", 32'(cyc + 1), 32'd4);
    chk("run start res", bus.RES, 32'h8);
    count_dones(8, seen);
    chk("run start no extra done", 32'(seen), 32'd0);

    // Reset after the second byte is captured aborts the operation.
    start_op(1'b1, 32'h1234_5678, 32'h1111_1111);
    repeat (2) @(posedge CK);
    @(negedge CK);
    RST = 1'b1;
    @(posedge CK);
    #1;
    RST = 1'b0;
    chk("abort busy", 32'(bus.BUSY), 32'd0);
    chk("abort done", 32'(bus.DONE), 32'd0);
    chk("abort res", bus.RES, 32'd0);
    chk("abort co_ovf", {30'd0, bus.CO, bus.OVF}, 32'd0);
    count_dones(8, seen);
    chk("abort no done", 32'(seen), 32'd0);
    start_op(1'b1, 32'h1234_5678, 32'h1111_1111);
    wait_done(cyc);
    chk("after abort latency", 32'(cyc), 32'd4);
    chk("after abort res", bus.RES, 32'h2345_6789);

    // Randomised operations against the full-width model, mixing idle gaps
    // with back-to-back requests.
    for (int i = 0; i < 40; i++) begin
      con = 1'($urandom_range(0, 1));
      a   = $urandom;
      b   = $urandom;
      case ($urandom_range(0, 5))
        0: a = 32'h8000_0000;
        1: a = 32'h7FFF_FFFF;
        2: b = a;
        default: ;
      endcase
      ref_model(con, a, b, r, co, ovf);
      if ($urandom_range(0, 1) == 0) repeat ($urandom_range(1, 3)) @(posedge CK);
      start_op(con, a, b);
      wait_done(cyc);
      chk($sformatf("rnd%0d latency", i), 32'(cyc), 32'd4);
      chk($sformatf("rnd%0d res", i), bus.RES, r);
      chk($sformatf("rnd%0d co_ovf", i), {30'd0, bus.CO, bus.OVF}, {30'd0, co, ovf});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fadsu8_mp_seq.md
Name: fadsu8_mp_seq

Overview:
- Multi-precision add/subtract sequencer that sits directly upstream of the 8-bit add/sub macro.
- Accepts two operands of NBYTES bytes each and feeds them to the macro one byte per clock, least significant byte first.
- Registers the macro's carry/borrow output between bytes and assembles the full-width result, final carry and signed overflow.
- Lets one 8-bit macro produce 16/24/32-bit add/sub results in the ECP datapath.

Parameters:
- NBYTES, 4, number of 8-bit lanes per operand (legal range 2..16).

Ports:
- CK  in  1  clock; all state changes on the rising edge.
- RST  in  1  reset; synchronous, active-high.
- START  in  1  request; sampled only when the block is not busy.
- CON  in  1  operation select, captured with START; 1 = add, 0 = subtract (A - B).
- A  in  8*NBYTES  operand A, captured with START.
- B  in  8*NBYTES  operand B, captured with START.
- BUSY  out  1  high from the cycle after START is accepted until the last byte is captured.
- DONE  out  1  one-cycle pulse; RES, CO and OVF are valid.
- RES  out  8*NBYTES  result; holds until the next START is accepted.
- CO  out  1  final carry (add) or not-borrow (subtract; 1 = no borrow).
- OVF  out  1  two's-complement overflow of the full-width operation.
- FA_A  out  8  current A byte to the macro.
- FA_B  out  8  current B byte to the macro.
- FA_BCI  out  1  carry/borrow-in to the macro.
- FA_CON  out  1  registered CON to the macro.
- FA_S  in  8  macro sum; combinational from FA_* in the same cycle.
- FA_BCO  in  1  macro carry/borrow-out.

Behaviour:
- Reset (synchronous, active-high): state IDLE. BUSY, DONE, CO, OVF = 0. RES = 0. Byte index = 0. FA_A, FA_B, FA_BCI, FA_CON = 0.
- States and transitions:
  - IDLE: START=1 captures A, B and CON. Sets carry register = ~CON (0 for add, 1 for subtract). Moves to RUN.
  - RUN, byte index i:
    - Drives FA_A = A[8i+7:8i], FA_B = B[8i+7:8i], FA_BCI = carry register, FA_CON = captured CON.
    - At the edge: RES[8i+7:8i] <= FA_S; carry register <= FA_BCO; i <= i+1.
    - After i = NBYTES-1, moves to DONE.
  - DONE (one cycle): DONE=1. CO = carry register.
    - OVF, using A7, B7 and S7 = MSBs of the top byte: add → (A7==B7) && (S7!=A7); subtract → (A7!=B7) && (S7!=A7).
    - If START=1 in this cycle, the request is accepted: capture and go to RUN (back-to-back). Otherwise go to IDLE.
- Latency: START accepted at edge t; bytes captured at edges t+1..t+NBYTES; DONE high between edges t+NBYTES and t+NBYTES+1.
- FA_* outputs are 0 in IDLE and DONE.
- START during RUN is ignored; no queueing.
- Input changes on A, B and CON after capture have no effect.
- CO and OVF hold their last values until the next DONE. They read 0 after reset.
- Reset mid-RUN: next cycle is IDLE, DONE is never asserted for the aborted operation, RES = 0.
- Arithmetic is unsigned modulo 2^(8*NBYTES). The subtract carry convention is carry = not-borrow.

Decomposition:
- Shared package holds: BYTE_W = 8; CON_ADD = 1'b1; CON_SUB = 1'b0; state encoding IDLE/RUN/DONE as a 2-bit typedef.
- Index counter width is $clog2(NBYTES).
- One natural sub-module: mp_shift_reg, a byte-wide shift register parameterised by NBYTES.
  - Operands shift right one byte per RUN cycle.
  - Result bytes shift in at the top.
  - Instantiated three times: A, B, RES.

Test Plan:
- Bench connects FA_* to the 8-bit add/sub macro; NBYTES = 4.
- CON=1, A=0x000000FF, B=0x00000001 → DONE exactly 4 cycles after START edge, RES=0x00000100, CO=0, OVF=0.
- CON=0, A=0x00000000, B=0x00000001 → RES=0xFFFFFFFF, CO=0 (borrow), OVF=0.
- CON=1, A=0x7FFFFFFF, B=0x00000001 → RES=0x80000000, CO=0, OVF=1.
- CON=0, A=0x80000000, B=0x00000001 → RES=0x7FFFFFFF, CO=1, OVF=1.
- Handshake:
  - START pulsed during RUN → ignored, RES unchanged from the first operation.
  - START held in the DONE cycle with A=1, B=2, add → second DONE 4 cycles later, RES=0x00000003.
- RST asserted after the second byte is captured → next cycle BUSY=0, DONE=0, RES=0. No DONE pulse ever appears for that operation. A following START computes correctly.
